// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing, tag types and pointer wrap helper for the physical register free list.
package phys_reg_free_list_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned NUM_ARCH_REGS = 35;
    localparam int unsigned LOG_PHYS      = $clog2(NUM_PHYS_REGS);
    localparam int unsigned DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned PTR_W         = $clog2(DEPTH);

    typedef logic [LOG_PHYS-1:0] preg_t;
    typedef logic [PTR_W-1:0]    ptr_t;

    // DEPTH is not a power of two, so wrap by explicit compare.
    function automatic ptr_t ptr_wrap_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/retire-facing bundle of the free list. master = pipeline side, slave = free list.
interface phys_reg_free_list_if;
    import phys_reg_free_list_pkg::*;

    logic  alloc_req;
    logic  alloc_valid;
    preg_t alloc_preg;
    logic  retire_valid;
    preg_t retire_free_preg;
    logic  recover;
    preg_t free_count;
    logic  underflow_err;

    modport master (
        output alloc_req, retire_valid, retire_free_preg, recover,
        input  alloc_valid, alloc_preg, free_count, underflow_err
    );

    modport slave (
        input  alloc_req, retire_valid, retire_free_preg, recover,
        output alloc_valid, alloc_preg, free_count, underflow_err
    );

endinterface

// File: rtl/phys_reg_free_list_wrap_ptr.sv
// Modulo-DEPTH pointer register: increments with wrap, or loads a new position.
module phys_reg_free_list_wrap_ptr
    import phys_reg_free_list_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t ptr
);

    // Load has priority over increment; reset returns to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_wrap_inc(ptr);
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative and retire heads,
// allowing one-cycle flush recovery by rewinding the speculative head.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    phys_reg_free_list_if.slave  fl
);

    preg_t mem [DEPTH];
    ptr_t  head;
    ptr_t  rhead;
    ptr_t  tail;
    ptr_t  rhead_new;
    preg_t free_count;
    preg_t spec_count;
    logic  underflow_err;
    logic  do_alloc;
    logic  retire_ok;

    // Qualify requests; a retire with nothing outstanding only pushes.
    always_comb begin
        do_alloc  = fl.alloc_req && (free_count != '0) && !fl.recover;
        retire_ok = fl.retire_valid && ((spec_count != '0) || do_alloc);
        rhead_new = retire_ok ? ptr_wrap_inc(rhead) : rhead;
    end

    // Recovery rewinds to the retire head as it stands after any same-cycle retire.
    phys_reg_free_list_wrap_ptr u_head (
        .clk      (CLK),
        .rst      (RESET),
        .inc      (do_alloc),
        .load     (fl.recover),
        .load_val (rhead_new),
        .ptr      (head)
    );

    phys_reg_free_list_wrap_ptr u_rhead (
        .clk      (CLK),
        .rst      (RESET),
        .inc      (retire_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (rhead)
    );

    phys_reg_free_list_wrap_ptr u_tail (
        .clk      (CLK),
        .rst      (RESET),
        .inc      (fl.retire_valid),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail)
    );

    // Tag storage: identity-following tags at reset, retired tags written at the tail.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= preg_t'(NUM_ARCH_REGS + i);
            end
        end else if (fl.retire_valid) begin
            mem[tail] <= fl.retire_free_preg;
        end
    end

    // Free/speculative occupancy and sticky underflow flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            free_count    <= preg_t'(DEPTH);
            spec_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (fl.recover) begin
                free_count <= preg_t'(DEPTH);
                spec_count <= '0;
            end else begin
                free_count <= free_count + preg_t'(fl.retire_valid) - preg_t'(do_alloc);
                spec_count <= spec_count + preg_t'(do_alloc) - preg_t'(retire_ok);
            end
            if (fl.retire_valid && !retire_ok) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign fl.alloc_valid   = (free_count != '0);
    assign fl.alloc_preg    = mem[head];
    assign fl.free_count    = free_count;
    assign fl.underflow_err = underflow_err;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based model of free and
// in-flight tags produces per-cycle expectations; a negedge monitor checks them.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    typedef struct {
        bit    av;
        preg_t preg;
        preg_t fc;
        bit    uf;
        bit    chk_preg;
        bit    chk_ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    phys_reg_free_list_if fl ();

    phys_reg_free_list u_dut (
        .CLK   (clk),
        .RESET (rst),
        .fl    (fl)
    );

    always #5 clk = ~clk;

    // Reference model: free tags in allocation order, in-flight tags in program order.
    preg_t free_q[$];
    preg_t spec_q[$];
    int    fc;
    bit    uf;
    bit    uf_seen;
    bit    mvalid = 1'b0;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) free_q.push_back(preg_t'(int'(NUM_ARCH_REGS) + i));
        fc      = int'(DEPTH);
        uf      = 1'b0;
        uf_seen = 1'b0;
    endtask

    task automatic model_apply(input bit rq, input bit rv, input preg_t tg, input bit rc);
        bit    alloc;
        preg_t t;
        alloc = rq && (fc != 0) && !rc;
        if (alloc) begin
            t = free_q.pop_front();
            spec_q.push_back(t);
            fc--;
        end
        if (rv) begin
            if (spec_q.size() != 0) void'(spec_q.pop_front());
            else begin
                uf      = 1'b1;
                uf_seen = 1'b1;
            end
            free_q.push_back(tg);
            fc++;
        end
        if (rc) begin
            // Flushed allocations return to the front of the list, oldest first.
            free_q = {spec_q, free_q};
            spec_q.delete();
            fc = int'(DEPTH);
        end
    endtask

    // Push the expectation for the current cycle, drive inputs, advance one cycle.
    task automatic step(input bit rq, input bit rv, input preg_t tg, input bit rc, input bit rs);
        exp_t e;
        if (mvalid) begin
            e.av       = (fc != 0);
            e.preg     = (free_q.size() != 0) ? free_q[0] : '0;
            e.fc       = preg_t'(fc);
            e.uf       = uf;
            e.chk_preg = (fc != 0) && (free_q.size() != 0) && !uf_seen;
            e.chk_ptr  = !uf_seen;
            exp_q.push_back(e);
        end
        fl.alloc_req        = rq;
        fl.retire_valid     = rv;
        fl.retire_free_preg = tg;
        fl.recover          = rc;
        rst                 = rs;
        if (rs) begin
            model_reset();
            mvalid = 1'b1;
        end else begin
            model_apply(rq, rv, tg, rc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (fl.alloc_valid !== e.av) begin
                n_fail++;
                $display("FAIL alloc_valid t=%0t got=%0b exp=%0b", $time, fl.alloc_valid, e.av);
            end
            n_checks++;
            if (fl.free_count !== e.fc) begin
                n_fail++;
                $display("FAIL free_count t=%0t got=%0d exp=%0d", $time, fl.free_count, e.fc);
            end
            n_checks++;
            if (fl.underflow_err !== e.uf) begin
                n_fail++;
                $display("FAIL underflow_err t=%0t got=%0b exp=%0b", $time, fl.underflow_err, e.uf);
            end
            if (e.chk_preg) begin
                n_checks++;
                if (fl.alloc_preg !== e.preg) begin
                    n_fail++;
                    $display("FAIL alloc_preg t=%0t got=%0d exp=%0d", $time, fl.alloc_preg, e.preg);
                end
            end
            // Each retire refills the slot it commits, so the write and retire pointers stay together.
            if (e.chk_ptr) begin
                n_checks++;
                if (u_dut.tail !== u_dut.rhead) begin
                    n_fail++;
                    $display("FAIL tail_rhead t=%0t tail=%0d rhead=%0d", $time, u_dut.tail, u_dut.rhead);
                end
            end
        end
    end

    initial begin
        bit    rq, rv, rc, rs, will_alloc;
        preg_t tg;
        int    ret_bias;

        fl.alloc_req        = 1'b0;
        fl.retire_valid     = 1'b0;
        fl.retire_free_preg = '0;
        fl.recover          = 1'b0;

        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Fill to empty, then one request with nothing left.
        for (int i = 0; i < 29; i++) step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        idle(1);
        // Retire into an empty list, with a request the same cycle that must be ignored.
        step(1, 1, preg_t'(7), 0, 0);
        idle(1);
        step(1, 0, '0, 0, 0);
        idle(1);

        // Allocate five, retire two, flush, then drain the whole list.
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 0);
        step(0, 1, preg_t'(3), 0, 0);
        step(0, 1, preg_t'(4), 0, 0);
        step(1, 0, '0, 1, 0);
        for (int i = 0; i < 29; i++) step(1, 0, '0, 0, 0);
        idle(1);

        // Same-cycle alloc and retire at free_count 10, then retire together with flush.
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 19; i++) step(1, 0, '0, 0, 0);
        step(1, 1, preg_t'(12), 0, 0);
        step(1, 1, preg_t'(13), 0, 0);
        step(1, 1, preg_t'(14), 1, 0);
        idle(2);

        // Retire with nothing outstanding: sticky error until reset.
        step(0, 0, '0, 0, 1);
        step(0, 1, preg_t'(9), 0, 0);
        idle(3);
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 0, 1);
        idle(2);

        // Randomized traffic with shifting retire pressure and occasional flush/reset.
        ret_bias = 2;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) ret_bias = int'($urandom_range(1, 6));
            rs = ($urandom_range(0, 700) == 0);
            rc = ($urandom_range(0, 50) == 0);
            rq = ($urandom_range(0, 3) != 0);
            will_alloc = rq && (fc != 0) && !rc;
            rv = ((spec_q.size() != 0) || will_alloc) && (int'($urandom_range(0, 6)) < ret_bias);
            tg = preg_t'($urandom_range(0, NUM_PHYS_REGS - 1));
            step(rq, rv, tg, rc, rs);
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
